// File: rtl/seq_serializer_6_if.sv
// seq_serializer_6 bus: parallel word in,
// serial frame stream out.
interface seq_serializer_6_if #(
  parameter int WIDTH = 6
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             data;
  logic             frame_start;
  logic             underrun;
  logic [7:0]       underrun_cnt;

  modport master (
    output din,
    output din_valid,
    input  din_ready,
    input  data,
    input  frame_start,
    input  underrun,
    input  underrun_cnt
  );

  modport slave (
    input  din,
    input  din_valid,
    output din_ready,
    output data,
    output frame_start,
    output underrun,
    output underrun_cnt
  );
endinterface

// File: rtl/seq_serializer_6.sv
// Parallel-to-serial framer: small FIFO in,
// gapless MSB-first frames out, idle fill.
module seq_serializer_6 #(
  parameter int               WIDTH     = 6,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] IDLE_WORD = '0
) (
  input logic              clk,
  input logic              rst_n,
  seq_serializer_6_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(WIDTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             data_q, data_d;
  logic             fs_q, fs_d;
  logic             ur_q, ur_d;
  logic [7:0]       ucnt_q, ucnt_d;

  logic             push;
  logic             pop;
  logic             load;
  logic [WIDTH-1:0] word;

  // FIFO bookkeeping, frame counter and shifter
  always_comb begin
    push      = bus.din_valid && (count_q != FULL);
    load      = (bit_cnt_q == '0);
    pop       = load && (count_q != '0);
    word      = pop ? mem_q[rd_ptr_q] : IDLE_WORD;
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    shift_d   = shift_q << 1;
    data_d    = shift_q[WIDTH-1];
    fs_d      = 1'b0;
    ur_d      = 1'b0;
    ucnt_d    = ucnt_q;
    bit_cnt_d = bit_cnt_q + BW'(1);

    if (bit_cnt_q == LAST)
      bit_cnt_d = '0;

    if (push) begin
      mem_d[wr_ptr_q] = bus.din;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end

    if (pop)
      rd_ptr_d = rd_ptr_q + AW'(1);

    unique case (1'b1)
      push && !pop: count_d = count_q + CW'(1);
      pop && !push: count_d = count_q - CW'(1);
      default:      count_d = count_q;
    endcase

    if (load) begin
      data_d  = word[WIDTH-1];
      shift_d = word << 1;
      fs_d    = 1'b1;
      ur_d    = !pop;
      if (!pop && ucnt_q != 8'hFF)
        ucnt_d = ucnt_q + 8'd1;
    end
  end

  // state registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q     <= '{default: '0};
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      data_q    <= 1'b0;
      fs_q      <= 1'b0;
      ur_q      <= 1'b0;
      ucnt_q    <= '0;
    end else begin
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      fs_q      <= fs_d;
      ur_q      <= ur_d;
      ucnt_q    <= ucnt_d;
    end
  end

  assign bus.din_ready    = (count_q != FULL);
  assign bus.data         = data_q;
  assign bus.frame_start  = fs_q;
  assign bus.underrun     = ur_q;
  assign bus.underrun_cnt = ucnt_q;

endmodule

// File: tb/tb_seq_serializer_6.sv
// Bench for seq_serializer_6: frame scoreboard
// plus directed steps on two parameterizations.
module tb_seq_serializer_6;

  typedef struct packed {
    logic d;
    logic fs;
    logic ur;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic rst2_n;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t       exp_q [$];
  logic [5:0] m_fifo [$];
  int         m_cnt  = 0;
  int         m_ucnt = 0;
  logic [5:0] m_w;
  logic       m_ur;
  logic       m_rdy;
  exp_t       e;

  seq_serializer_6_if #(.WIDTH(6)) b1 ();
  seq_serializer_6_if #(.WIDTH(6)) b2 ();

  seq_serializer_6 u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b1)
  );

  seq_serializer_6 #(
    .WIDTH     (6),
    .DEPTH     (4),
    .IDLE_WORD (6'h2D)
  ) u_dut2 (
    .clk   (clk),
    .rst_n (rst2_n),
    .bus   (b2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // reference model: accept words, build frames
  always @(posedge clk) begin
    if (rst_n === 1'b1) begin
      m_rdy = (m_fifo.size() != 2);
      if (m_cnt == 0) begin
        if (m_fifo.size() > 0) begin
          m_w  = m_fifo.pop_front();
          m_ur = 1'b0;
        end else begin
          m_w  = 6'h00;
          m_ur = 1'b1;
          if (m_ucnt < 255) m_ucnt++;
        end
        for (int i = 5; i >= 0; i--)
          exp_q.push_back('{m_w[i], i == 5,
                            m_ur && i == 5});
      end
      if (b1.din_valid && m_rdy)
        m_fifo.push_back(b1.din);
      m_cnt = (m_cnt + 1) % 6;
    end
  end

  // reset discards all model state
  always @(negedge rst_n) begin
    m_fifo.delete();
    exp_q.delete();
    m_cnt  = 0;
    m_ucnt = 0;
  end

  // scoreboard compare, away from active edge
  always @(negedge clk) begin
    if (rst_n === 1'b1 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("sb_data", 32'(b1.data), 32'(e.d));
      check("sb_frame_start", 32'(b1.frame_start),
            32'(e.fs));
      check("sb_underrun", 32'(b1.underrun),
            32'(e.ur));
      check("sb_din_ready", 32'(b1.din_ready),
            32'(m_fifo.size() != 2));
      check("sb_underrun_cnt",
            32'(b1.underrun_cnt), 32'(m_ucnt));
    end
  end

  logic [5:0] words [4];
  logic [5:0] idle2;
  int t;

  initial begin
    words = '{6'h2A, 6'h15, 6'h3F, 6'h01};
    idle2 = 6'h2D;
    rst_n = 1'b0;
    rst2_n = 1'b0;
    b1.din = '0;
    b1.din_valid = 1'b0;
    b2.din = '0;
    b2.din_valid = 1'b0;
    repeat (3) @(negedge clk);

    // reset values
    check("rst_data", 32'(b1.data), 0);
    check("rst_frame_start", 32'(b1.frame_start), 0);
    check("rst_underrun", 32'(b1.underrun), 0);
    check("rst_ucnt", 32'(b1.underrun_cnt), 0);
    check("rst_din_ready", 32'(b1.din_ready), 1);

    // single word pushed on bit_cnt=1 edge
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("f0_underrun", 32'(b1.underrun), 1);
    b1.din = 6'b01_1100;
    b1.din_valid = 1'b1;
    @(negedge clk);
    b1.din_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("f1_start", 32'(b1.frame_start), 1);
    check("f1_msb", 32'(b1.data), 0);
    check("f1_underrun", 32'(b1.underrun), 0);
    check("f1_ucnt", 32'(b1.underrun_cnt), 1);
    @(negedge clk);
    check("f1_bit4", 32'(b1.data), 1);

    // back-to-back under sustained valid
    for (int i = 0; i < 4; i++) begin
      b1.din = words[i];
      b1.din_valid = 1'b1;
      t = 0;
      while (!b1.din_ready && t < 50) begin
        @(negedge clk);
        t++;
      end
      check("b2b_accept_bound", 32'(t < 50), 1);
      @(negedge clk);
    end
    b1.din_valid = 1'b0;
    repeat (40) @(negedge clk);

    // saturation of the idle counter
    repeat (1800) @(negedge clk);
    check("sat_ucnt", 32'(b1.underrun_cnt), 255);

    // push exactly on a load edge
    t = 0;
    while (m_cnt != 0 && t < 10) begin
      @(negedge clk);
      t++;
    end
    check("load_align_bound", 32'(t < 10), 1);
    b1.din = 6'h3F;
    b1.din_valid = 1'b1;
    @(negedge clk);
    b1.din_valid = 1'b0;
    check("le_idle_start", 32'(b1.frame_start), 1);
    check("le_idle_ur", 32'(b1.underrun), 1);
    check("le_idle_data", 32'(b1.data), 0);
    repeat (6) @(negedge clk);
    check("le_next_start", 32'(b1.frame_start), 1);
    check("le_next_ur", 32'(b1.underrun), 0);
    check("le_next_data", 32'(b1.data), 1);

    // mid-frame reset with two words queued
    t = 0;
    while (m_cnt != 1 && t < 10) begin
      @(negedge clk);
      t++;
    end
    check("mr_align_bound", 32'(t < 10), 1);
    b1.din = 6'h2A;
    b1.din_valid = 1'b1;
    @(negedge clk);
    b1.din = 6'h15;
    @(negedge clk);
    b1.din_valid = 1'b0;
    check("mr_full", 32'(b1.din_ready), 0);
    rst_n = 1'b0;
    #1;
    check("mr_data", 32'(b1.data), 0);
    check("mr_frame_start", 32'(b1.frame_start), 0);
    check("mr_underrun", 32'(b1.underrun), 0);
    check("mr_ucnt", 32'(b1.underrun_cnt), 0);
    check("mr_din_ready", 32'(b1.din_ready), 1);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("mr_first_idle", 32'(b1.underrun), 1);
    repeat (6) @(negedge clk);
    check("mr_second_idle", 32'(b1.underrun), 1);
    repeat (6) @(negedge clk);

    // DEPTH=4, IDLE_WORD=6'h2D instance
    @(negedge clk);
    #2 rst2_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("p2_idle_bit", 32'(b2.data),
            32'(idle2[5-i]));
      check("p2_fs", 32'(b2.frame_start),
            32'(i == 0));
      check("p2_ur", 32'(b2.underrun), 32'(i == 0));
      check("p2_ready", 32'(b2.din_ready),
            32'(i < 4));
      if (i < 4) begin
        b2.din = words[i];
        b2.din_valid = 1'b1;
      end else begin
        b2.din_valid = 1'b0;
      end
    end
    @(negedge clk);
    check("p2_word0_msb", 32'(b2.data),
          32'(words[0][5]));
    check("p2_word0_ur", 32'(b2.underrun), 0);
    check("p2_ready_after_pop",
          32'(b2.din_ready), 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
